// File: rtl/cmd_parser.sv
// ASCII command parser: assembles <op><digits><term> from a UART byte stream,
// issues each command over valid/ready and drives a display code.
module cmd_parser #(
  parameter int MAX_DIGITS = 3,
  parameter int ARG_W      = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  output logic [7:0]       disp_code,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] DISP_ERR = 8'hEE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    ISSUE  = 2'd2,
    ERROR  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_OP   = 3'd0,
    C_DIG  = 3'd1,
    C_TERM = 3'd2,
    C_SP   = 3'd3,
    C_BAD  = 3'd4
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t c;
    case (b)
      8'd102, 8'd114, 8'd108: c = C_OP;
      8'd10, 8'd13, 8'd59:    c = C_TERM;
      8'd32:                  c = C_SP;
      default: begin
        if ((b >= 8'd48) && (b <= 8'd57)) begin
          c = C_DIG;
        end else begin
          c = C_BAD;
        end
      end
    endcase
    return c;
  endfunction

  function automatic logic [1:0] op_code(input logic [7:0] b);
    logic [1:0] o;
    case (b)
      8'd114:  o = 2'd1;
      8'd108:  o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [1:0]       op_r, op_s;
  logic [ARG_W-1:0] arg_r, arg_s;
  logic [7:0]       disp_r, disp_s;
  logic             err_r, err_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;

  byte_class_t      cls_s;
  logic [3:0]       digit_s;

  // ASCII '0'..'9' carry their value in the low nibble.
  assign cls_s   = classify(rx_data);
  assign digit_s = rx_data[3:0];

  // Next-state and next-output decode for the parser FSM.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    op_s    = op_r;
    arg_s   = arg_r;
    disp_s  = disp_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          case (cls_s)
            C_OP: begin
              op_s    = op_code(rx_data);
              arg_s   = {ARG_W{1'b0}};
              count_s = {CNT_W{1'b0}};
              disp_s  = rx_data;
              state_s = DIGITS;
            end
            C_SP, C_TERM: begin
              state_s = IDLE;
            end
            default: begin
              state_s = ERROR;
              err_s   = 1'b1;
              disp_s  = DISP_ERR;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      DIGITS: begin
        if (rx_valid) begin
          case (cls_s)
            C_DIG: begin
              if (count_r < CNT_W'(MAX_DIGITS)) begin
                arg_s   = (arg_r * ARG_W'(4'd10)) + ARG_W'(digit_s);
                count_s = count_r + CNT_W'(1'b1);
                disp_s  = {4'd0, digit_s};
              end else begin
                state_s = ERROR;
                err_s   = 1'b1;
                disp_s  = DISP_ERR;
              end
            end
            C_TERM: begin
              if (count_r != {CNT_W{1'b0}}) begin
                state_s = ISSUE;
              end else begin
                // A bare opcode is rejected but needs no draining.
                state_s = IDLE;
                err_s   = 1'b1;
                disp_s  = DISP_ERR;
              end
            end
            default: begin
              state_s = ERROR;
              err_s   = 1'b1;
              disp_s  = DISP_ERR;
            end
          endcase
        end else begin
          state_s = DIGITS;
        end
      end
      ISSUE: begin
        // Bytes arriving while a command is pending are overruns.
        err_s = rx_valid;
        if (valid_r && cmd_ready) begin
          state_s = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      ERROR: begin
        if (rx_valid && (cls_s == C_TERM)) begin
          state_s = IDLE;
        end else begin
          state_s = ERROR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    valid_s = (state_s == ISSUE);
    busy_s  = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
      count_r <= {CNT_W{1'b0}};
      op_r    <= 2'd0;
      arg_r   <= {ARG_W{1'b0}};
      disp_r  <= DISP_ERR;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      op_r    <= op_s;
      arg_r   <= arg_s;
      disp_r  <= disp_s;
      err_r   <= err_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign cmd_valid = valid_r;
  assign cmd_op    = op_r;
  assign cmd_arg   = arg_r;
  assign disp_code = disp_r;
  assign err       = err_r;
  assign busy      = busy_r;

endmodule
